// File: rtl/ks_program_memory.sv
`default_nettype none
// ============================================================================
// Module   : ks_program_memory
// Purpose  : 32 x 16 program/data RAM for the K&S core with a byte-serial boot
//            loader; loader built only when KS_MEM_LOADER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ks_program_memory #(
   parameter int DEPTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ram_addr,
   input  logic [15:0] ram_wdata,
   input  logic        ram_write_enable,
   output logic [15:0] ram_rdata,
   input  logic        load_valid,
   input  logic [7:0]  load_byte,
   input  logic        load_last,
   output logic        load_ready,
   output logic        cpu_rst_n,
   output logic        boot_done,
   output logic        load_odd
);

   logic [15:0] r_mem [0:DEPTH-1];
   logic        w_we;
   logic [4:0]  w_waddr;
   logic [15:0] w_wdata;
   logic        r_run;

`ifdef KS_MEM_LOADER_EN
   localparam logic [1:0] S_LOAD_HI = 2'd0;
   localparam logic [1:0] S_LOAD_LO = 2'd1;
   localparam logic [1:0] S_RUN     = 2'd2;

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic [4:0] r_wptr;
   logic [7:0] r_hi;
   logic       r_odd;
   logic       w_xfer;

   assign load_ready = (r_state != S_RUN);
   assign w_xfer     = load_valid && load_ready;
   assign load_odd   = r_odd;

   // The single RAM write port is steered by the loader until RUN, then by the core.
   always_comb begin
      w_state_nxt = r_state;
      w_we        = 1'b0;
      w_waddr     = r_wptr;
      w_wdata     = {load_byte, 8'h00};
      case (r_state)
         S_LOAD_HI: begin
            if (w_xfer) begin
               if (load_last) begin
                  w_we        = 1'b1;
                  w_state_nxt = S_RUN;
               end else begin
                  w_state_nxt = S_LOAD_LO;
               end
            end
         end
         S_LOAD_LO: begin
            if (w_xfer) begin
               w_we        = 1'b1;
               w_wdata     = {r_hi, load_byte};
               w_state_nxt = (load_last || (r_wptr == 5'(DEPTH - 1))) ? S_RUN : S_LOAD_HI;
            end
         end
         S_RUN: begin
            w_we    = ram_write_enable;
            w_waddr = ram_addr;
            w_wdata = ram_wdata;
         end
         default: w_state_nxt = S_LOAD_HI;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_LOAD_HI;
         r_wptr  <= 5'd0;
         r_hi    <= 8'h00;
         r_odd   <= 1'b0;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // Registered from the next state so the core leaves reset on the final byte's edge.
         r_run   <= (w_state_nxt == S_RUN);
         if (w_xfer && (r_state == S_LOAD_HI)) begin
            r_hi <= load_byte;
            if (load_last) begin
               r_odd <= 1'b1;
            end
         end
         if (w_xfer && (r_state == S_LOAD_LO) && (r_wptr != 5'(DEPTH - 1))) begin
            r_wptr <= r_wptr + 5'd1;
         end
      end
   end
`else
   logic w_unused_load;

   assign w_unused_load = &{1'b0, load_valid, load_byte, load_last};
   assign load_ready    = 1'b0;
   assign load_odd      = 1'b0;
   assign w_we          = ram_write_enable;
   assign w_waddr       = ram_addr;
   assign w_wdata       = ram_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run <= 1'b0;
      end else begin
         r_run <= 1'b1;
      end
   end
`endif

   assign cpu_rst_n = r_run;
   assign boot_done = r_run;
   assign ram_rdata = r_mem[ram_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 16'h0000;
         end
      end else if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ks_program_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ks_program_memory
// Purpose  : Randomized self-checking bench for ks_program_memory; covers the
//            loader build when KS_MEM_LOADER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ks_program_memory;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  ram_addr = 5'd0;
   logic [15:0] ram_wdata = 16'h0000;
   logic        ram_write_enable = 1'b0;
   logic [15:0] ram_rdata;
   logic        load_valid = 1'b0;
   logic [7:0]  load_byte = 8'h00;
   logic        load_last = 1'b0;
   logic        load_ready;
   logic        cpu_rst_n;
   logic        boot_done;
   logic        load_odd;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] m_mem [0:31];
   bit          m_run = 1'b0;

   ks_program_memory #(.DEPTH(32)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ram_addr         (ram_addr),
      .ram_wdata        (ram_wdata),
      .ram_write_enable (ram_write_enable),
      .ram_rdata        (ram_rdata),
      .load_valid       (load_valid),
      .load_byte        (load_byte),
      .load_last        (load_last),
      .load_ready       (load_ready),
      .cpu_rst_n        (cpu_rst_n),
      .boot_done        (boot_done),
      .load_odd         (load_odd)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

`ifdef KS_MEM_LOADER_EN
   logic [7:0] m_img[$];
   bit         m_odd = 1'b0;

   // Image bytes fill words high byte first; anything not covered stays 0.
   function automatic void build_mem();
      for (int k = 0; k < 32; k++) m_mem[k] = 16'h0000;
      for (int i = 0; i < m_img.size(); i++) begin
         if (i % 2 == 0) m_mem[i/2][15:8] = m_img[i];
         else            m_mem[i/2][7:0]  = m_img[i];
      end
   endfunction

   task automatic send(input logic [7:0] b, input logic last);
      bit acc;
      acc        = !m_run;
      load_valid = 1'b1;
      load_byte  = b;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_byte  = 8'($urandom);
      load_last  = 1'($urandom);
      if (acc) begin
         m_img.push_back(b);
         if (last || m_img.size() == 64) begin
            m_run = 1'b1;
            m_odd = (m_img.size() % 2) == 1;
            build_mem();
         end
      end
   endtask
`endif

   task automatic do_reset();
      load_valid       = 1'b0;
      ram_write_enable = 1'b0;
      #2 rst_n = 1'b0;
      #3 rst_n = 1'b1;
      for (int k = 0; k < 32; k++) m_mem[k] = 16'h0000;
      m_run = 1'b0;
`ifdef KS_MEM_LOADER_EN
      m_img.delete();
      m_odd = 1'b0;
`endif
      tick();
`ifndef KS_MEM_LOADER_EN
      m_run = 1'b1;
`endif
   endtask

   task automatic test_reset();
      bit exp_ready;
`ifdef KS_MEM_LOADER_EN
      exp_ready = 1'b1;
`else
      exp_ready = 1'b0;
`endif
      rst_n = 1'b0;
      #2;
      n_checks++;
      if ({cpu_rst_n, boot_done, load_odd} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags got={cpu_rst_n,boot_done,load_odd}=%b exp=000", {cpu_rst_n, boot_done, load_odd});
      end
      n_checks++;
      if (load_ready !== exp_ready) begin
         n_fail++;
         $display("FAIL reset_load_ready got=%b exp=%b", load_ready, exp_ready);
      end
      #4 rst_n = 1'b1;
      #1;
      n_checks++;
      if (cpu_rst_n !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_cpu_rst_n got=%b exp=0", cpu_rst_n);
      end
      for (int k = 0; k < 32; k++) m_mem[k] = 16'h0000;
      tick();
`ifdef KS_MEM_LOADER_EN
      m_run = 1'b0;
`else
      m_run = 1'b1;
`endif
      n_checks++;
      if ({cpu_rst_n, boot_done} !== {m_run, m_run} || load_ready !== exp_ready) begin
         n_fail++;
         $display("FAIL post_reset_state got cpu_rst_n=%b boot_done=%b load_ready=%b exp %b %b %b",
                  cpu_rst_n, boot_done, load_ready, m_run, m_run, exp_ready);
      end
      for (int a = 0; a < 32; a++) begin
         ram_addr = 5'(a);
         #1;
         n_checks++;
         if (ram_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mem addr=%0d got=%h exp=0000", a, ram_rdata);
         end
      end
      tick();
   endtask

   task automatic test_runtime_write();
      logic [4:0]  a;
      logic [15:0] d;
      ram_addr         = 5'd20;
      ram_wdata        = 16'h1234;
      ram_write_enable = 1'b1;
      tick();
      ram_write_enable = 1'b0;
      m_mem[20]        = 16'h1234;
      n_checks++;
      if (ram_rdata !== 16'h1234) begin
         n_fail++;
         $display("FAIL run_write_20 got=%h exp=1234", ram_rdata);
      end
      for (int n = 0; n < 40; n++) begin
         a                = 5'($urandom);
         d                = 16'($urandom);
         ram_addr         = a;
         ram_wdata        = d;
         ram_write_enable = 1'($urandom);
         load_valid       = 1'($urandom);
         load_byte        = 8'($urandom);
         load_last        = 1'($urandom);
         tick();
         if (ram_write_enable) m_mem[a] = d;
         ram_write_enable = 1'b0;
         load_valid       = 1'b0;
         ram_addr         = 5'($urandom);
         #1;
         n_checks++;
         if (ram_rdata !== m_mem[ram_addr] || load_ready !== 1'b0 || cpu_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL run_random addr=%0d got=%h exp=%h ready=%b cpu_rst_n=%b",
                     ram_addr, ram_rdata, m_mem[ram_addr], load_ready, cpu_rst_n);
         end
      end
      tick();
   endtask

`ifdef KS_MEM_LOADER_EN
   task automatic test_short_image();
      logic [7:0] img [4] = '{8'h81, 8'h05, 8'hFF, 8'h00};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(img[i], i == 3);
         n_checks++;
         if (cpu_rst_n !== (i == 3)) begin
            n_fail++;
            $display("FAIL short_cpu_rst_n byte=%0d got=%b exp=%b", i, cpu_rst_n, i == 3);
         end
      end
      n_checks++;
      if ({load_ready, boot_done, load_odd} !== 3'b010) begin
         n_fail++;
         $display("FAIL short_flags got={ready,done,odd}=%b exp=010", {load_ready, boot_done, load_odd});
      end
      for (int a = 0; a < 32; a++) begin
         ram_addr = 5'(a);
         #1;
         n_checks++;
         if (ram_rdata !== m_mem[a]) begin
            n_fail++;
            $display("FAIL short_mem addr=%0d got=%h exp=%h", a, ram_rdata, m_mem[a]);
         end
      end
      ram_addr = 5'd1;
      #1;
      n_checks++;
      if (ram_rdata !== 16'hFF00) begin
         n_fail++;
         $display("FAIL short_mem1 got=%h exp=ff00", ram_rdata);
      end
      tick();
   endtask

   task automatic test_odd_image();
      logic [7:0] img [3] = '{8'h01, 8'h1F, 8'hA1};
      do_reset();
      for (int i = 0; i < 3; i++) send(img[i], i == 2);
      ram_addr = 5'd1;
      #1;
      n_checks++;
      if (ram_rdata !== 16'hA100 || load_odd !== 1'b1 || cpu_rst_n !== 1'b1 || load_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL odd_image mem1=%h odd=%b cpu_rst_n=%b ready=%b exp a100 1 1 0",
                  ram_rdata, load_odd, cpu_rst_n, load_ready);
      end
      ram_addr = 5'd0;
      #1;
      n_checks++;
      if (ram_rdata !== 16'h011F) begin
         n_fail++;
         $display("FAIL odd_image_mem0 got=%h exp=011f", ram_rdata);
      end
      tick();
   endtask

   task automatic test_load_write_ignored();
      do_reset();
      ram_addr         = 5'd20;
      ram_wdata        = 16'h1234;
      ram_write_enable = 1'b1;
      tick();
      ram_write_enable = 1'b0;
      n_checks++;
      if (ram_rdata !== 16'h0000 || load_ready !== 1'b1 || cpu_rst_n !== 1'b0) begin
         n_fail++;
         $display("FAIL load_write_ignored mem20=%h ready=%b cpu_rst_n=%b exp 0000 1 0",
                  ram_rdata, load_ready, cpu_rst_n);
      end
   endtask

   task automatic test_mid_load_reset();
      logic [7:0] b [3];
      do_reset();
      for (int i = 0; i < 3; i++) begin
         b[i] = 8'($urandom);
         send(b[i], 1'b0);
      end
      ram_addr = 5'd0;
      #1;
      n_checks++;
      if (ram_rdata !== {b[0], b[1]}) begin
         n_fail++;
         $display("FAIL mid_load_word0 got=%h exp=%h", ram_rdata, {b[0], b[1]});
      end
      do_reset();
      for (int a = 0; a < 32; a++) begin
         ram_addr = 5'(a);
         #1;
         n_checks++;
         if (ram_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_load_cleared addr=%0d got=%h exp=0000", a, ram_rdata);
         end
      end
      tick();
      send(8'h3C, 1'b0);
      send(8'hC3, 1'b0);
      ram_addr = 5'd0;
      #1;
      n_checks++;
      if (ram_rdata !== 16'h3CC3 || load_ready !== 1'b1 || cpu_rst_n !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_load_restart mem0=%h ready=%b cpu_rst_n=%b exp 3cc3 1 0",
                  ram_rdata, load_ready, cpu_rst_n);
      end
      tick();
   endtask

   task automatic test_full_image();
      do_reset();
      for (int i = 0; i < 64; i++) begin
         while ($urandom_range(0, 3) == 0) tick();
         send(8'($urandom), 1'b0);
         n_checks++;
         if (cpu_rst_n !== (i == 63)) begin
            n_fail++;
            $display("FAIL full_cpu_rst_n byte=%0d got=%b exp=%b", i, cpu_rst_n, i == 63);
         end
      end
      n_checks++;
      if (load_ready !== 1'b0 || load_odd !== 1'b0) begin
         n_fail++;
         $display("FAIL full_65th_ready got ready=%b odd=%b exp 0 0", load_ready, load_odd);
      end
      send(8'hEE, 1'b1);
      for (int a = 0; a < 32; a++) begin
         ram_addr = 5'(a);
         #1;
         n_checks++;
         if (ram_rdata !== m_mem[a]) begin
            n_fail++;
            $display("FAIL full_mem addr=%0d got=%h exp=%h", a, ram_rdata, m_mem[a]);
         end
      end
      tick();
   endtask

   task automatic test_random_images();
      int len;
      for (int n = 0; n < 5; n++) begin
         do_reset();
         len = $urandom_range(1, 70);
         for (int i = 0; i < len; i++) begin
            send(8'($urandom), (i == len - 1) && ($urandom_range(0, 2) != 0));
            n_checks++;
            if (cpu_rst_n !== m_run || load_odd !== m_odd) begin
               n_fail++;
               $display("FAIL rand_flags img=%0d byte=%0d cpu_rst_n=%b odd=%b exp %b %b",
                        n, i, cpu_rst_n, load_odd, m_run, m_odd);
            end
         end
         if (m_run) begin
            for (int a = 0; a < 32; a++) begin
               ram_addr = 5'(a);
               #1;
               n_checks++;
               if (ram_rdata !== m_mem[a]) begin
                  n_fail++;
                  $display("FAIL rand_mem img=%0d addr=%0d got=%h exp=%h", n, a, ram_rdata, m_mem[a]);
               end
            end
            tick();
         end
      end
   endtask
`else
   task automatic test_mid_run_reset();
      ram_addr         = 5'd7;
      ram_wdata        = 16'hBEEF;
      ram_write_enable = 1'b1;
      tick();
      ram_write_enable = 1'b0;
      rst_n            = 1'b0;
      #2;
      n_checks++;
      if (cpu_rst_n !== 1'b0 || boot_done !== 1'b0 || ram_rdata !== 16'h0000) begin
         n_fail++;
         $display("FAIL mid_run_reset cpu_rst_n=%b done=%b mem7=%h exp 0 0 0000",
                  cpu_rst_n, boot_done, ram_rdata);
      end
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (cpu_rst_n !== 1'b1 || boot_done !== 1'b1 || load_odd !== 1'b0) begin
         n_fail++;
         $display("FAIL after_mid_run_reset cpu_rst_n=%b done=%b odd=%b exp 1 1 0",
                  cpu_rst_n, boot_done, load_odd);
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef KS_MEM_LOADER_EN
      test_short_image();
      test_odd_image();
      test_load_write_ignored();
      test_mid_load_reset();
      test_full_image();
      test_runtime_write();
      test_random_images();
`else
      test_runtime_write();
      test_mid_run_reset();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
